// File: rtl/pc_pkg.sv
// pc_pkg
//   Shared definitions for the program-counter unit and the instruction
//   decoder: default widths, the phase in which the PC updates, and the
//   PC operation encoding together with its priority decode.
package pc_pkg;

   localparam int         PC_ADDR_W       = 16;
   localparam int         PC_PHASE_W      = 3;
   localparam int         PC_STACK_DEPTH  = 4;
   localparam logic [2:0] PC_UPDATE_PHASE = 3'b100;

   typedef enum logic [2:0] {
      SEQ      = 3'd0,
      JUMP     = 3'd1,
      CALL     = 3'd2,
      RET      = 3'd3,
      CONFLICT = 3'd4
   } pc_op_e;

   // Priority: call+ret conflict, return, call, jump, sequential.
   function automatic pc_op_e decode_op(input logic call, input logic ret,
                                        input logic j_flag);
      pc_op_e op;
      if (call && ret) begin
         op = CONFLICT;
      end else if (ret) begin
         op = RET;
      end else if (call) begin
         op = CALL;
      end else if (j_flag) begin
         op = JUMP;
      end else begin
         op = SEQ;
      end
      return op;
   endfunction

endpackage

// File: rtl/pc_unit_stack_return_stack.sv
// return_stack
//   LIFO of return addresses, count 0..STACK_DEPTH.
//   Ports:
//     clock, rst      rising-edge clock, asynchronous active-low reset
//     push, pop       push din / pop top (ignored when full / empty)
//     din             address to push
//     top             entry on top of the stack (don't-care when empty)
//     full, empty     registered occupancy flags
//     overflow        push requested while full (combinational)
//     underflow       pop requested while empty (combinational)
module return_stack import pc_pkg::*; #(
   parameter int ADDR_W      = PC_ADDR_W,
   parameter int STACK_DEPTH = PC_STACK_DEPTH
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

   logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic [PTR_W-1:0]  top_idx_s;
   logic              full_r;
   logic              empty_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign push_ok_s = push && !full_r;
   assign pop_ok_s  = pop && !empty_r;
   assign overflow  = push && full_r;
   assign underflow = pop && empty_r;

   // When full the low pointer bits wrap to 0, so minus one still lands on
   // the last slot; the power-of-two depth makes this exact.
   assign top_idx_s = count_r[PTR_W-1:0] - PTR_W'(1);
   assign top       = mem_r[top_idx_s];
   assign full      = full_r;
   assign empty     = empty_r;

   // Next occupancy from the accepted push/pop.
   always_comb begin
      count_next_s = count_r;
      if (push_ok_s && !pop_ok_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (pop_ok_s && !push_ok_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Occupancy counter and flags, registered from the next count.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         count_r <= {CNT_W{1'b0}};
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         count_r <= count_next_s;
         full_r  <= (count_next_s == DEPTH_C);
         empty_r <= (count_next_s == {CNT_W{1'b0}});
      end
   end

   // Entry storage; contents are don't-care after reset.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[count_r[PTR_W-1:0]] <= din;
      end
   end

endmodule

// File: rtl/pc_unit_stack.sv
// pc_unit_stack
//   Program counter with a hardware return-address stack. Updates once per
//   processor cycle, in UPDATE_PHASE, unless stalled.
//   Ports:
//     clock, rst    rising-edge clock, asynchronous active-low reset
//     phase         current processor phase
//     stall         freeze PC and stack in the update phase
//     j_flag        taken jump/branch to j_addr+1
//     call, ret     subroutine call / return
//     j_addr        computed target (PC + ext_d)
//     pc_out        current program counter
//     stack_empty   stack holds no entries
//     stack_full    stack holds STACK_DEPTH entries
//     stack_err     sticky overflow / underflow / call+ret conflict
module pc_unit_stack import pc_pkg::*; #(
   parameter int                 ADDR_W       = PC_ADDR_W,
   parameter int                 PHASE_W      = PC_PHASE_W,
   parameter logic [PHASE_W-1:0] UPDATE_PHASE = PC_UPDATE_PHASE,
   parameter int                 STACK_DEPTH  = PC_STACK_DEPTH,
   parameter logic [ADDR_W-1:0]  RESET_PC     = {ADDR_W{1'b0}}
) (
   input  logic               clock,
   input  logic               rst,
   input  logic [PHASE_W-1:0] phase,
   input  logic               stall,
   input  logic               j_flag,
   input  logic               call,
   input  logic               ret,
   input  logic [ADDR_W-1:0]  j_addr,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               stack_empty,
   output logic               stack_full,
   output logic               stack_err
);

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_next_s;
   logic [ADDR_W-1:0] pc_inc_s;
   logic [ADDR_W-1:0] jmp_tgt_s;
   logic [ADDR_W-1:0] top_s;
   logic              window_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic              overflow_s;
   logic              underflow_s;
   logic              err_set_s;
   logic              err_r;
   pc_op_e            op_s;

   assign window_s  = (phase == UPDATE_PHASE) && !stall;
   assign op_s      = decode_op(call, ret, j_flag);
   // Both wrap modulo 2^ADDR_W; j_addr already points at the current
   // instruction, so the next fetch is one beyond it.
   assign pc_inc_s  = pc_r + ADDR_W'(1);
   assign jmp_tgt_s = j_addr + ADDR_W'(1);
   assign push_s    = window_s && (op_s == CALL);
   assign pop_s     = window_s && (op_s == RET);
   assign err_set_s = window_s && ((op_s == CONFLICT) || overflow_s || underflow_s);

   return_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clock     (clock),
      .rst       (rst),
      .push      (push_s),
      .pop       (pop_s),
      .din       (pc_inc_s),
      .top       (top_s),
      .full      (full_s),
      .empty     (empty_s),
      .overflow  (overflow_s),
      .underflow (underflow_s)
   );

   // Next-PC select by operation.
   always_comb begin
      pc_next_s = pc_inc_s;
      case (op_s)
         SEQ:      pc_next_s = pc_inc_s;
         JUMP:     pc_next_s = jmp_tgt_s;
         CALL:     pc_next_s = jmp_tgt_s;
         RET: begin
            if (empty_s) begin
               pc_next_s = pc_inc_s;
            end else begin
               pc_next_s = top_s;
            end
         end
         CONFLICT: pc_next_s = pc_inc_s;
         default:  pc_next_s = pc_inc_s;
      endcase
   end

   // PC register and sticky error flag, written only in the update window.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         pc_r  <= RESET_PC;
         err_r <= 1'b0;
      end else if (window_s) begin
         pc_r  <= pc_next_s;
         err_r <= err_r | err_set_s;
      end
   end

   assign pc_out      = pc_r;
   assign stack_empty = empty_s;
   assign stack_full  = full_s;
   assign stack_err   = err_r;

endmodule

// File: tb/tb_pc_unit_stack.sv
module tb_pc_unit_stack;

   logic        clock = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  phase = 3'd0;
   logic        stall = 1'b0;
   logic        j_flag = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [15:0] j_addr = 16'h0000;
   logic [15:0] pc_out;
   logic        stack_empty;
   logic        stack_full;
   logic        stack_err;

   int n_checks = 0;
   int n_err = 0;

   pc_unit_stack dut (
      .clock       (clock),
      .rst         (rst),
      .phase       (phase),
      .stall       (stall),
      .j_flag      (j_flag),
      .call        (call),
      .ret         (ret),
      .j_addr      (j_addr),
      .pc_out      (pc_out),
      .stack_empty (stack_empty),
      .stack_full  (stack_full),
      .stack_err   (stack_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        stall;
      logic        j_flag;
      logic        call;
      logic        ret;
      logic [15:0] j_addr;
      logic [15:0] exp_pc;
      logic        exp_empty;
      logic        exp_full;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic s, input logic j, input logic c,
                               input logic r, input logic [15:0] a,
                               input logic [15:0] pc, input logic e,
                               input logic f, input logic er);
      vec_t v;
      v.stall = s; v.j_flag = j; v.call = c; v.ret = r; v.j_addr = a;
      v.exp_pc = pc; v.exp_empty = e; v.exp_full = f; v.exp_err = er;
      return v;
   endfunction

   function automatic logic [18:0] obs();
      return {pc_out, stack_empty, stack_full, stack_err};
   endfunction

   task automatic check(input string name, input logic [18:0] got,
                        input logic [18:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, expected pc=%h empty=%b full=%b err=%b",
                  name, got[18:3], got[2], got[1], got[0],
                  exp[18:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      phase = 3'd0; stall = 1'b0; j_flag = 1'b0; call = 1'b0; ret = 1'b0;
      j_addr = 16'h0000;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // One full processor cycle (phases 0..4) with the controls held the whole
   // time; outputs must hold through phases 0..3.
   task automatic do_op(input string name, input logic s, input logic j,
                        input logic c, input logic r, input logic [15:0] a,
                        input logic [18:0] hold_exp);
      stall = s; j_flag = j; call = c; ret = r; j_addr = a;
      for (int p = 0; p < 5; p++) begin
         phase = 3'(p);
         tick();
         if (p < 4) check({name, "_hold"}, obs(), hold_exp);
      end
      stall = 1'b0; j_flag = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   logic [18:0]  prev;
   logic [15:0]  m_pc;
   logic [15:0]  m_q[$];
   logic         m_err;
   logic [31:0]  rnd;

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      check("reset", obs(), {16'h0000, 1'b1, 1'b0, 1'b0});

      // ---------------- three idle processor cycles ----------------
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 5; p++) begin
            phase = 3'(p);
            tick();
            check("seq_phase", obs(), {16'(k + ((p == 4) ? 1 : 0)), 1'b1, 1'b0, 1'b0});
         end
      end

      // ---------------- asynchronous reset in phase 2 ----------------
      phase = 3'd0; tick();
      phase = 3'd1; tick();
      phase = 3'd2;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst", obs(), {16'h0000, 1'b1, 1'b0, 1'b0});
      tick();
      rst = 1'b1;

      // ---------------- table-driven sequence ----------------
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'(i + 1), 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 16'h0040, 16'h0041, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 16'h000F, 16'h0010, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 16'h0100, 16'h0101, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 16'h0200, 16'h0201, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 16'h0300, 16'h0301, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 16'h0400, 16'h0401, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 16'h0500, 16'h0501, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 16'h0600, 16'h0601, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0402, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0302, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0202, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0012, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0013, 1, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 16'hFFFE, 16'hFFFF, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 16'hFFFF, 16'h0000, 1, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 16'h1234, 16'h0000, 1, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1));

      prev = {16'h0000, 1'b1, 1'b0, 1'b0};
      foreach (tbl[i]) begin
         do_op($sformatf("vec%0d", i), tbl[i].stall, tbl[i].j_flag,
               tbl[i].call, tbl[i].ret, tbl[i].j_addr, prev);
         prev = {tbl[i].exp_pc, tbl[i].exp_empty, tbl[i].exp_full, tbl[i].exp_err};
         check($sformatf("vec%0d", i), obs(), prev);
      end

      // ---------------- call+ret conflict ----------------
      do_reset();
      check("conf_reset", obs(), {16'h0000, 1'b1, 1'b0, 1'b0});
      do_op("conf_call", 0, 0, 1, 0, 16'h0AAA, {16'h0000, 1'b1, 1'b0, 1'b0});
      check("conf_call", obs(), {16'h0AAB, 1'b0, 1'b0, 1'b0});
      do_op("conf_both", 0, 1, 1, 1, 16'h5555, {16'h0AAB, 1'b0, 1'b0, 1'b0});
      check("conf_both", obs(), {16'h0AAC, 1'b0, 1'b0, 1'b1});
      do_op("conf_ret", 0, 0, 0, 1, 16'h0000, {16'h0AAC, 1'b0, 1'b0, 1'b1});
      check("conf_ret", obs(), {16'h0001, 1'b1, 1'b0, 1'b1});

      // ---------------- randomized run against a reference model ----------------
      do_reset();
      m_pc = 16'h0000;
      m_q.delete();
      m_err = 1'b0;
      for (int n = 0; n < 600; n++) begin
         rnd = $urandom;
         phase  = (rnd[1:0] == 2'd0) ? 3'($urandom_range(0, 7)) : 3'd4;
         stall  = (rnd[4:2] == 3'd0);
         call   = (rnd[6:5] == 2'd0);
         ret    = (rnd[8:7] == 2'd0);
         j_flag = (rnd[10:9] == 2'd0);
         rnd = $urandom;
         j_addr = (rnd[18:16] == 3'd0) ? 16'hFFFF : rnd[15:0];
         tick();
         if (phase == 3'd4 && !stall) begin
            if (call && ret) begin
               m_pc = m_pc + 16'h0001;
               m_err = 1'b1;
            end else if (ret) begin
               if (m_q.size() > 0) begin
                  m_pc = m_q.pop_back();
               end else begin
                  m_pc = m_pc + 16'h0001;
                  m_err = 1'b1;
               end
            end else if (call) begin
               if (m_q.size() < 4) m_q.push_back(m_pc + 16'h0001);
               else m_err = 1'b1;
               m_pc = j_addr + 16'h0001;
            end else if (j_flag) begin
               m_pc = j_addr + 16'h0001;
            end else begin
               m_pc = m_pc + 16'h0001;
            end
         end
         check($sformatf("rand%0d", n), obs(),
               {m_pc, (m_q.size() == 0), (m_q.size() == 4), m_err});
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_unit_stack.md
Name: pc_unit_stack

Overview:
- Parametrised program counter with a hardware return-address stack for subroutine call and return.
- Sits at the front of the multi-phase processor datapath, in the same place as the current PC.
- Updates only in the configured update phase. Adds stall, call and return, and stack-error reporting.

Parameters:
- ADDR_W, 16: width of PC, jump address and stack entries.
- PHASE_W, 3: width of the phase input.
- UPDATE_PHASE, 3'b100: phase value in which the PC updates.
- STACK_DEPTH, 4: number of return-stack entries. Must be a power of two and at least 2.
- RESET_PC, 0: PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- phase  in  PHASE_W  current processor phase.
- stall  in  1  1 = hold PC and stack in the update phase.
- j_flag  in  1  taken jump/branch.
- call  in  1  subroutine call; jumps to j_addr and pushes the return address.
- ret  in  1  subroutine return; pops the return address.
- j_addr  in  ADDR_W  computed target (PC + ext_d).
- pc_out  out  ADDR_W  current program counter.
- stack_empty  out  1  stack holds 0 entries.
- stack_full  out  1  stack holds STACK_DEPTH entries.
- stack_err  out  1  sticky error flag: overflow, underflow or call+ret conflict.

Behaviour:
- Reset (rst=0, asynchronous): pc_out=RESET_PC, stack count=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Update window: a cycle with phase==UPDATE_PHASE and stall==0. Outside the window, pc_out, the stack and the flags hold.
- Action in the window, by priority:
  1. call=1 and ret=1: treated as sequential (pc_out<=pc_out+1), no stack change, stack_err<=1.
  2. ret=1: if not empty, pc_out<=top entry, then pop. If empty, pc_out<=pc_out+1, stack_err<=1.
  3. call=1 (j_flag ignored): push pc_out+1, pc_out<=j_addr+1. If full, no push, jump still taken, stack_err<=1.
  4. j_flag=1: pc_out<=j_addr+1.
  5. Otherwise: pc_out<=pc_out+1.
- The +1 on jump targets is required: j_addr is PC+ext_d and the next fetch needs +1.
- Latency: the new pc_out is visible in the cycle after the update edge. Control inputs are sampled only at that edge.
- Arithmetic is modulo 2^ADDR_W. All-ones + 1 = 0, both for sequential increment and for j_addr+1. No carry-out.
- Stack is LIFO with count 0..STACK_DEPTH.
  - stack_full and stack_empty are registered from count and update on the same edge as the push or pop.
  - Pushing into the last free slot sets stack_full immediately.
- stack_err is sticky; it clears only on reset.
- Stall in the update phase freezes the update completely. The update is not deferred to a later phase.
- Reset mid-operation: asynchronous clear at any phase, and any in-flight push or pop is abandoned.

Decomposition:
- Shared package pc_pkg:
  - PC_OP enum: SEQ, JUMP, CALL, RET, CONFLICT.
  - Default widths and the UPDATE_PHASE constant.
  - Shared with the decoder.
- Sub-module return_stack (parameters ADDR_W, STACK_DEPTH):
  - Inputs: push, pop, din.
  - Outputs: top, full, empty, overflow, underflow.
  - Register array plus pointer.
- pc_unit_stack holds the op-select logic, the PC register and the sticky error flag.

Test Plan:
- Reset, then 3 full phase cycles (0..4) with no controls: pc_out = 0→1→2→3, changing only after phase 4. Assert rst low at phase 2: pc_out=0 immediately.
- pc_out=5, j_flag=1, j_addr=0x0040 in phase 4: pc_out=0x0041.
- Call: pc_out=0x0010, call=1, j_addr=0x0100: pc_out=0x0101, stack_empty=0.
- Return: a later ret=1 gives pc_out=0x0011 and stack_empty=1.
- 5 consecutive calls with STACK_DEPTH=4: stack_full=1 after the 4th call. On the 5th call the jump is taken and stack_err=1. Four rets then return the 4 pushed addresses in LIFO order. A 5th ret gives pc_out+1 and stack_err stays 1.
- Wrap and stall: pc_out=0xFFFF, sequential → 0x0000. j_addr=0xFFFF with j_flag → 0x0000. stall=1 in phase 4 → pc_out unchanged.
- call=1 and ret=1 together: pc_out+1, stack count unchanged, stack_err=1.
